// File: rtl/mem_ctr_burst.sv
// Burst line memory controller: whole-line READ_LINE / WRITE_LINE bus transactions
// against local storage, with a fixed controller latency and registered bus outputs.
module mem_ctr_burst #(
  parameter int ADDR_W     = 10,
  parameter int LINE_BYTES = 16,
  parameter int DATA_W     = 16,
  parameter int DELAY      = 100
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        cmd_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] d_in,
  output logic [1:0]        cmd_out,
  output logic              cmd_oe,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  output logic              busy
);

  localparam int BEATS = LINE_BYTES * 32'sd8 / DATA_W;
  localparam int WLAT  = (DELAY > BEATS) ? DELAY : BEATS;
  localparam int CW    = $clog2(WLAT + 32'sd1);
  localparam int WORDS = (32'sd2 ** ADDR_W) * BEATS;
  localparam int IW    = (WORDS > 32'sd1) ? $clog2(WORDS) : 32'sd1;

  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(32'sd1);
  localparam logic [CW-1:0] DELAY_C = CW'(DELAY);
  localparam logic [CW-1:0] WLAT_C  = CW'(WLAT);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RESP  = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_SEND = 3'd2,
    WR_RECV = 3'd3,
    WR_WAIT = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t              state_r, state_n;
  logic [CW-1:0]       cnt_r, cnt_n;
  logic [ADDR_W-1:0]   addr_r, addr_n;
  logic                wr_en_s;
  logic [IW-1:0]       wr_idx_s, rd_idx_s;
  logic [DATA_W-1:0]   mem_r [WORDS];
  logic [1:0]          cmd_out_r;
  logic                cmd_oe_r, d_oe_r, busy_r;
  logic [DATA_W-1:0]   d_out_r;

  // Storage word holding beat 'beat' of line 'line'; beats are little-endian within the line.
  function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] line, input logic [CW-1:0] beat);
    return IW'(line) * IW'(BEATS) + IW'(beat);
  endfunction

  // Next-state, counter and write-port decode; cnt_r is the cycle offset from the command,
  // except in RD_SEND where it restarts at zero and indexes the outgoing beat.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    addr_n   = addr_r;
    wr_en_s  = 1'b0;
    wr_idx_s = word_idx(addr_r, cnt_r);
    case (state_r)
      IDLE: begin
        cnt_n = ZERO_C;
        if (cmd_in == CMD_READ) begin
          addr_n = addr_in;
          if (DELAY_C == ONE_C) begin
            state_n = RD_SEND;
          end else begin
            state_n = RD_WAIT;
            cnt_n   = ONE_C;
          end
        end else if (cmd_in == CMD_WRITE) begin
          addr_n   = addr_in;
          wr_en_s  = 1'b1;
          wr_idx_s = word_idx(addr_in, ZERO_C);
          cnt_n    = ONE_C;
          if (BEATS_C != ONE_C) begin
            state_n = WR_RECV;
          end else if (WLAT_C == ONE_C) begin
            state_n = WR_RESP;
            cnt_n   = ZERO_C;
          end else begin
            state_n = WR_WAIT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RD_WAIT: begin
        cnt_n = cnt_r + ONE_C;
        if (cnt_r + ONE_C == DELAY_C) begin
          state_n = RD_SEND;
          cnt_n   = ZERO_C;
        end else begin
          state_n = RD_WAIT;
        end
      end
      RD_SEND: begin
        if (cnt_r == BEATS_C - ONE_C) begin
          state_n = IDLE;
          cnt_n   = ZERO_C;
        end else begin
          cnt_n = cnt_r + ONE_C;
        end
      end
      WR_RECV: begin
        wr_en_s = 1'b1;
        cnt_n   = cnt_r + ONE_C;
        if (cnt_r != BEATS_C - ONE_C) begin
          state_n = WR_RECV;
        end else if (cnt_r + ONE_C == WLAT_C) begin
          state_n = WR_RESP;
          cnt_n   = ZERO_C;
        end else begin
          state_n = WR_WAIT;
        end
      end
      WR_WAIT: begin
        cnt_n = cnt_r + ONE_C;
        if (cnt_r + ONE_C == WLAT_C) begin
          state_n = WR_RESP;
          cnt_n   = ZERO_C;
        end else begin
          state_n = WR_WAIT;
        end
      end
      WR_RESP: begin
        state_n = IDLE;
        cnt_n   = ZERO_C;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = ZERO_C;
      end
    endcase
    rd_idx_s = word_idx(addr_n, cnt_n);
  end

  // Line storage: no reset, and a beat arriving alongside RESET is dropped.
  always_ff @(posedge CLK) begin
    if (wr_en_s && !RESET) begin
      mem_r[wr_idx_s] <= d_in;
    end
  end

  // State register; bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= IDLE;
      cnt_r     <= ZERO_C;
      addr_r    <= {ADDR_W{1'b0}};
      cmd_out_r <= CMD_NOP;
      cmd_oe_r  <= 1'b0;
      d_out_r   <= {DATA_W{1'b0}};
      d_oe_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      addr_r    <= addr_n;
      cmd_oe_r  <= (state_n == RD_SEND) || (state_n == WR_RESP);
      cmd_out_r <= ((state_n == RD_SEND) || (state_n == WR_RESP)) ? CMD_RESP : CMD_NOP;
      d_oe_r    <= (state_n == RD_SEND);
      d_out_r   <= (state_n == RD_SEND) ? mem_r[rd_idx_s] : {DATA_W{1'b0}};
      busy_r    <= (state_n != IDLE);
    end
  end

  assign cmd_out = cmd_out_r;
  assign cmd_oe  = cmd_oe_r;
  assign d_out   = d_out_r;
  assign d_oe    = d_oe_r;
  assign busy    = busy_r;

endmodule
